// File: rtl/stack_program_feeder_pkg.sv
// Shared constants for the stack program feeder: FSM states, opcode
// encodings and the issue-window length of each opcode.
package stack_program_feeder_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CPURST = 2'd1,
    S_ISSUE  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [3:0] OP_PUSH  = 4'h0;
  localparam logic [3:0] OP_PUSHI = 4'h1;
  localparam logic [3:0] OP_PUSHH = 4'h2;
  localparam logic [3:0] OP_OUT   = 4'h3;
  localparam logic [3:0] OP_POP   = 4'h4;
  localparam logic [3:0] OP_ADD   = 4'h5;
  localparam logic [3:0] OP_SUB   = 4'h6;
  localparam logic [3:0] OP_AND   = 4'h7;
  localparam logic [3:0] OP_OR    = 4'h8;
  localparam logic [3:0] OP_MULT  = 4'h9;
  localparam logic [3:0] OP_DIV   = 4'hA;
  localparam logic [3:0] OP_DUP   = 4'hB;
  localparam logic [3:0] OP_SHL   = 4'hC;
  localparam logic [3:0] OP_SHR   = 4'hD;
  localparam logic [3:0] OP_SWAP  = 4'hE;
  localparam logic [3:0] OP_LOAD  = 4'hF;

  // Issue window lengths: opcode cycle plus operand repeats.
  localparam logic [2:0] LEN_SHORT = 3'd2;
  localparam logic [2:0] LEN_MID   = 3'd3;
  localparam logic [2:0] LEN_LONG  = 3'd4;

  function automatic logic [2:0] op_len(input logic [3:0] op);
    case (op)
      OP_PUSHI, OP_PUSHH, OP_ADD, OP_SUB, OP_AND, OP_OR: op_len = LEN_MID;
      OP_MULT, OP_DIV, OP_SHL, OP_SHR:                   op_len = LEN_LONG;
      default:                                           op_len = LEN_SHORT;
    endcase
  endfunction

endpackage

// File: rtl/stack_program_feeder_prog_mem.sv
// 16x8 program store: synchronous write, combinational read, no reset.
module feeder_prog_mem (
  input  logic       clk,
  input  logic       we_i,
  input  logic [3:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [3:0] raddr_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem_q [16];

  // Write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stack_program_feeder.sv
// Feeds a stored program to a stack CPU one nibble per cycle: resets the
// CPU, then issues each entry as opcode followed by operand repeats.
module stack_program_feeder
  import stack_program_feeder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic [4:0] prog_len,
  input  logic       start,
  input  logic       loop_en,
  input  logic       stop,
  output logic [3:0] nib_out,
  output logic       cpu_rst,
  output logic       busy,
  output logic       done,
  output logic [3:0] pc
);

  state_e     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [1:0] cyc_q, cyc_d;
  logic [2:0] ilen_q, ilen_d;
  logic [3:0] opr_q, opr_d;
  logic [4:0] len_q, len_d;
  logic       stop_q, stop_d;
  logic [3:0] nib_q, nib_d;
  logic       cpu_rst_q, busy_q, done_q;
  logic       new_instr, stop_seen, instr_end, last_entry;
  logic [7:0] rdata;

  // Writes are locked out while a run is using the store.
  feeder_prog_mem u_mem (
    .clk     (clk),
    .we_i    (prog_we & ~busy_q),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (pc_d),
    .rdata_o (rdata)
  );

  assign stop_seen  = stop_q | stop;
  assign instr_end  = ({1'b0, cyc_q} == (ilen_q - 3'd1));
  assign last_entry = ({1'b0, pc_q} == (len_q - 5'd1));

  // Next state; outputs are computed for the next state so they can be registered.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cyc_d     = cyc_q;
    len_d     = len_q;
    stop_d    = stop_q;
    ilen_d    = ilen_q;
    opr_d     = opr_q;
    nib_d     = 4'd0;
    new_instr = 1'b0;
    case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (start) begin
          len_d   = (prog_len > 5'd16) ? 5'd16 : prog_len;
          pc_d    = 4'd0;
          state_d = S_CPURST;
        end
      end
      S_CPURST: begin
        if (len_q == 5'd0 || stop_seen) begin
          state_d = S_DONE;
        end else begin
          state_d   = S_ISSUE;
          pc_d      = 4'd0;
          cyc_d     = 2'd0;
          new_instr = 1'b1;
        end
      end
      S_ISSUE: begin
        stop_d = stop_seen;
        if (instr_end) begin
          if (stop_seen || (last_entry && !loop_en)) begin
            state_d = S_DONE;
          end else begin
            pc_d      = last_entry ? 4'd0 : pc_q + 4'd1;
            cyc_d     = 2'd0;
            new_instr = 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 2'd1;
        end
      end
      default: begin
        stop_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    if (new_instr) begin
      ilen_d = op_len(rdata[7:4]);
      opr_d  = rdata[3:0];
      nib_d  = rdata[7:4];
    end else if (state_d == S_ISSUE) begin
      nib_d = opr_q;
    end
  end

  // State and output registers; reset also drives a CPU reset next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= 4'd0;
      cyc_q     <= 2'd0;
      ilen_q    <= LEN_SHORT;
      opr_q     <= 4'd0;
      len_q     <= 5'd0;
      stop_q    <= 1'b0;
      nib_q     <= 4'd0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cyc_q     <= cyc_d;
      ilen_q    <= ilen_d;
      opr_q     <= opr_d;
      len_q     <= len_d;
      stop_q    <= stop_d;
      nib_q     <= nib_d;
      cpu_rst_q <= (state_d == S_CPURST);
      busy_q    <= (state_d == S_CPURST) || (state_d == S_ISSUE);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign nib_out = nib_q;
  assign cpu_rst = cpu_rst_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pc      = pc_q;

endmodule

// File: doc/stack_program_feeder.md
STACK_PROGRAM_FEEDER -- requirements
Module: stack_program_feeder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: rst  in  1  reset; synchronous, active-high.
REQ-003 SHALL have: prog_we  in  1  program write strobe.
REQ-004 SHALL have: prog_addr  in  4  program write address.
REQ-005 SHALL have: prog_data  in  8  program entry; [7:4] opcode, [3:0] operand.
REQ-006 SHALL have: prog_len  in  5  instruction count, 0..16.
REQ-007 SHALL have: start  in  1  one-cycle run request.
REQ-008 SHALL have: loop_en  in  1  wrap to entry 0 after the last entry.
REQ-009 SHALL have: stop  in  1  halt at the next instruction boundary.
REQ-010 SHALL have: nib_out  out  4  nibble bus to the CPU inbits.
REQ-011 SHALL have: cpu_rst  out  1  CPU reset drive.
REQ-012 SHALL have: busy  out  1  run in progress.
REQ-013 SHALL have: done  out  1  one-cycle pulse when a run completes.
REQ-014 SHALL have: pc  out  4  index of the entry being issued.

Function
REQ-015 SHALL register all outputs; the value in cycle t is the value the CPU samples at the edge ending t.
REQ-016 SHALL hold 16x8 program storage, written on prog_we only while busy=0.
REQ-017 SHALL implement states IDLE, CPURST, ISSUE, DONE.
REQ-018 In IDLE, SHALL drive nib_out=0, cpu_rst=0, busy=0.
REQ-019 On start in IDLE, SHALL latch min(prog_len,16), enter CPURST, drive cpu_rst=1 for exactly 1 cycle, and set busy=1.
REQ-020 On start outside IDLE, SHALL ignore the request.
REQ-021 From CPURST, SHALL enter DONE if the latched length is 0; otherwise ISSUE with pc=0.
REQ-022 In ISSUE, SHALL issue entry pc over L cycles: cycle 0 nib_out=opcode, cycles 1..L-1 nib_out=operand.
REQ-023 L SHALL be 2 for opcodes 0,3,4,B,E,F.
REQ-024 L SHALL be 3 for opcodes 1,2,5,6,7,8.
REQ-025 L SHALL be 4 for opcodes 9,A,C,D.
REQ-026 Instructions SHALL be issued back-to-back with no gap cycles.
REQ-027 At the end of the last entry, SHALL wrap pc to 0 if loop_en=1 (no cpu_rst); otherwise enter DONE.
REQ-028 stop SHALL be sticky until the current instruction ends, then the block SHALL enter DONE.
REQ-029 DONE SHALL last 1 cycle: done=1, busy=0, nib_out=0, then IDLE.
REQ-030 If stop and end-of-program coincide, SHALL enter DONE once, with a single done pulse.

Reset
REQ-031 On rst, SHALL go to IDLE with nib_out=0, busy=0, done=0, pc=0, and cpu_rst=1 in the following cycle, so the CPU also resets.
REQ-032 rst mid-instruction SHALL abandon the instruction immediately.
REQ-033 Program storage SHALL NOT be cleared by rst.

Structure
REQ-034 Opcode constants (OP_PUSH..OP_LOAD) and per-opcode length values SHALL reside in the shared constants.v.
REQ-035 Program storage SHALL be one sub-module, feeder_prog_mem: 16x8, synchronous write, combinational read.

Verification
REQ-036 Program {0x15,0x30}, len 2, start -> cpu_rst=1 for 1 cycle; nib_out 1,5,5,3,0; done pulse; stack_cpu io_out[3:0]=5.
REQ-037 Program {0x13,0x17,0x90,0x30} -> MULT window is 4 cycles (9,0,0,0); stack_cpu io_out[3:0]=1 (21=0x15, high nibble on top).
REQ-038 prog_len=0, start -> cpu_rst 1 cycle, then done pulse; nib_out stays 0.
REQ-039 Program {0x00}, len 1, loop_en=1 -> nib_out 0 continuously with busy=1; stop mid-instruction -> done pulse 2 cycles later at most.
REQ-040 rst asserted during the MULT operand cycle -> next cycle cpu_rst=1, busy=0, nib_out=0; program rerun gives the same result as REQ-037.
REQ-041 prog_we to addr 0 with 0x3F while busy -> ignored; rerun issues the original entry 0.
